mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, bus address width; DATA_WIDTH, 32, bus data width; SEL_WIDTH, 4, byte-select width; TIMEOUT_CYCLES, 16, max wait for bus_ack (range 2..255).
REQ-002 Ports SHALL be (name direction width meaning):
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- inst_req  in  1  instruction-fetch request.
- inst_addr  in  ADDR_WIDTH  fetch address.
- inst_rdata  out  DATA_WIDTH  fetched word.
- inst_ready  out  1  fetch-complete pulse.
- data_req  in  1  data-access request.
- data_we  in  1  1=write, 0=read.
- data_sel  in  SEL_WIDTH  byte lanes.
- data_addr  in  ADDR_WIDTH  data address.
- data_wdata  in  DATA_WIDTH  store data.
- data_rdata  out  DATA_WIDTH  load data.
- data_ready  out  1  access-complete pulse.
- bus_req  out  1  memory bus request.
- bus_we  out  1  bus write enable.
- bus_sel  out  SEL_WIDTH  bus byte lanes.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_rdata  in  DATA_WIDTH  bus read data.
- bus_ack  in  1  bus transfer done, one cycle.
- stall_from_inst  out  1  fetch waiting, to pipeline control.
- stall_from_data  out  1  data access waiting, to pipeline control.
- timeout_error  out  1  sticky bus-timeout flag.

Function
REQ-003 Arbiter SHALL share one memory bus between fetch and data ports with FSM states IDLE, GRANT_I, GRANT_D.
REQ-004 Requester handshake: req and fields SHALL stay stable until ready; ready SHALL be a registered one-cycle pulse; a requester's req SHALL be ignored in the cycle its ready is high.
REQ-005 IDLE: data_req SHALL win over inst_req (data belongs to the older instruction); the chosen request's fields SHALL be latched; next state GRANT_D or GRANT_I; nothing pending -> stay IDLE.
REQ-006 GRANT_x: bus_req=1; bus_addr/bus_we/bus_sel/bus_wdata SHALL come from latched fields; fetch grants SHALL drive bus_we=0, bus_sel=all ones, bus_wdata=0.
REQ-007 On bus_ack in GRANT_x: bus_rdata SHALL be captured into x_rdata, x_ready pulsed next cycle, bus_req dropped next cycle.
REQ-008 Back-to-back: on ack, if the other port is requesting (subject to REQ-004), the FSM SHALL go directly to its grant (alternation, no IDLE bubble); otherwise IDLE.
REQ-009 Data writes: data_rdata SHALL be unchanged on write completion.
REQ-010 x_rdata SHALL hold its value until the next completion on that port.
REQ-011 stall_from_x SHALL be combinational: x_req AND NOT x_ready.
REQ-012 Wait counter SHALL clear on grant entry and increment each grant cycle without bus_ack; on reaching TIMEOUT_CYCLES: set timeout_error, drop bus_req, pulse x_ready with x_rdata=0, go IDLE.
REQ-013 timeout_error SHALL be cleared only by reset.
REQ-014 bus_ack in IDLE SHALL be ignored; an ack on the cycle the counter reaches TIMEOUT_CYCLES SHALL count as success (no error).
REQ-015 Bus outputs SHALL be registered; latency request-to-bus_req = 1 cycle, bus_ack-to-ready = 1 cycle.

Reset
REQ-016 reset low SHALL immediately force: state IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, inst_rdata=0, data_rdata=0, inst_ready=0, data_ready=0, counter=0, timeout_error=0.
REQ-017 Reset mid-transfer SHALL abandon the transfer without a ready pulse; a late bus_ack after release SHALL be ignored.

Verification
REQ-018 Fetch alone: inst_req, inst_addr=0x100, bus_ack 3 cycles after bus_req with bus_rdata=0x24010005 -> inst_rdata=0x24010005, inst_ready one pulse, bus_we=0, bus_sel=0xF.
REQ-019 Contention: inst_req and data_req (read 0x200) same cycle -> data granted first, then fetch with no idle cycle; stall_from_inst high until inst_ready.
REQ-020 Store: data_we=1, data_sel=0x3, data_addr=0x40, data_wdata=0xDEADBEEF -> bus carries identical values; data_ready pulses; data_rdata unchanged.
REQ-021 Timeout: TIMEOUT_CYCLES=4, no bus_ack -> bus_req drops after 4 grant cycles, data_ready pulses with data_rdata=0, timeout_error stays 1 until reset.
REQ-022 Reset mid-grant: reset low during GRANT_I -> bus_req 0 in same cycle; after release, stray bus_ack yields no ready.
REQ-023 Stale request: requester holds inst_req through the ready cycle -> exactly one bus transfer, not two.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: shares one request/ack bus between instruction
// fetch and data access, with data priority, back-to-back alternation and a wait timeout.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_ready,

  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [SEL_WIDTH-1:0]  data_sel,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_ready,

  output logic                  bus_req,
  output logic                  bus_we,
  output logic [SEL_WIDTH-1:0]  bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,

  output logic                  stall_from_inst,
  output logic                  stall_from_data,
  output logic                  timeout_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] wait_count;

  logic inst_pending;
  logic data_pending;
  logic granted;
  logic timed_out;
  logic done;
  logic start_d;
  logic start_i;
  logic release_bus;

  // A requester's req is not a new request in the cycle its ready pulse is high.
  assign inst_pending    = inst_req & ~inst_ready;
  assign data_pending    = data_req & ~data_ready;
  assign stall_from_inst = inst_pending;
  assign stall_from_data = data_pending;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    granted     = 1'b0;
    timed_out   = 1'b0;
    done        = 1'b0;
    start_d     = 1'b0;
    start_i     = 1'b0;
    release_bus = 1'b0;

    granted   = (state == GRANT_I) || (state == GRANT_D);
    // An ack in the final wait cycle wins over the timeout.
    timed_out = granted && !bus_ack && (wait_count == LAST_WAIT);
    done      = granted && (bus_ack || timed_out);

    case (state)
      IDLE: begin
        start_d = data_pending;
        start_i = !data_pending && inst_pending;
      end
      GRANT_I: start_d = bus_ack && data_pending;
      GRANT_D: start_i = bus_ack && inst_pending;
      default: ;
    endcase

    release_bus = done && !start_d && !start_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_count    <= '0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_sel       <= '0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      inst_rdata    <= '0;
      data_rdata    <= '0;
      inst_ready    <= 1'b0;
      data_ready    <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;

      if (start_d) begin
        state      <= GRANT_D;
        wait_count <= '0;
        bus_req    <= 1'b1;
        bus_we     <= data_we;
        bus_sel    <= data_sel;
        bus_addr   <= data_addr;
        bus_wdata  <= data_wdata;
      end else if (start_i) begin
        state      <= GRANT_I;
        wait_count <= '0;
        bus_req    <= 1'b1;
        bus_we     <= 1'b0;
        bus_sel    <= '1;
        bus_addr   <= inst_addr;
        bus_wdata  <= '0;
      end else if (release_bus) begin
        state   <= IDLE;
        bus_req <= 1'b0;
      end else if (granted) begin
        wait_count <= wait_count + 8'd1;
      end

      if (done && state == GRANT_I) begin
        inst_ready <= 1'b1;
        inst_rdata <= bus_ack ? bus_rdata : '0;
      end

      // Write completions leave data_rdata holding the last load result.
      if (done && state == GRANT_D) begin
        data_ready <= 1'b1;
        if (!bus_ack)
          data_rdata <= '0;
        else if (!bus_we)
          data_rdata <= bus_rdata;
      end

      if (timed_out)
        timeout_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, contention, store, timeout,
// stale request and reset mid-grant, checked with immediate assertions.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_ready;
  logic          data_req;
  logic          data_we;
  logic [SW-1:0] data_sel;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_ready;
  logic          bus_req;
  logic          bus_we;
  logic [SW-1:0] bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          stall_from_inst;
  logic          stall_from_data;
  logic          timeout_error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .SEL_WIDTH     (SW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_rdata     (inst_rdata),
    .inst_ready     (inst_ready),
    .data_req       (data_req),
    .data_we        (data_we),
    .data_sel       (data_sel),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .data_ready     (data_ready),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_sel        (bus_sel),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .stall_from_inst(stall_from_inst),
    .stall_from_data(stall_from_data),
    .timeout_error  (timeout_error)
  );

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset      = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_sel   = '0;
    data_addr  = '0;
    data_wdata = '0;
    bus_rdata  = '0;
    bus_ack    = 1'b0;

    // Reset state
    step(); step();
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_inst_rdata", inst_rdata, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_timeout", timeout_error, 0);
    reset = 1'b1;
    step();
    check("idle_bus_req", bus_req, 0);

    // Fetch alone; ack in the 4th grant cycle is the boundary success case
    inst_req  = 1'b1;
    inst_addr = 32'h100;
    #1 check("f_stall_inst", stall_from_inst, 1);
    step();
    check("f_bus_req", bus_req, 1);
    check("f_bus_addr", bus_addr, 32'h100);
    check("f_bus_we", bus_we, 0);
    check("f_bus_sel", bus_sel, 4'hF);
    check("f_bus_wdata", bus_wdata, 0);
    step();
    step();
    step();
    check("f_bus_req_wait", bus_req, 1);
    check("f_ready_early", inst_ready, 0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h2401_0005;
    step();
    bus_ack = 1'b0;
    check("f_inst_ready", inst_ready, 1);
    check("f_inst_rdata", inst_rdata, 32'h2401_0005);
    check("f_bus_req_drop", bus_req, 0);
    check("f_no_timeout", timeout_error, 0);
    #1 check("f_stall_clear", stall_from_inst, 0);
    // inst_req still held through the ready cycle: must not start a second transfer
    step();
    check("stale_bus_req", bus_req, 0);
    check("stale_ready_once", inst_ready, 0);
    check("stale_rdata_hold", inst_rdata, 32'h2401_0005);
    inst_req = 1'b0;
    step();
    check("stale_bus_req2", bus_req, 0);

    // Contention: data wins, then fetch follows with no idle cycle
    inst_req  = 1'b1;
    inst_addr = 32'h300;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_sel  = 4'hF;
    data_addr = 32'h200;
    step();
    check("c_bus_req", bus_req, 1);
    check("c_bus_addr_d", bus_addr, 32'h200);
    check("c_bus_we", bus_we, 0);
    check("c_stall_inst", stall_from_inst, 1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_2222;
    step();
    bus_ack = 1'b0;
    check("c_data_ready", data_ready, 1);
    check("c_data_rdata", data_rdata, 32'h1111_2222);
    check("c_b2b_bus_req", bus_req, 1);
    check("c_bus_addr_i", bus_addr, 32'h300);
    check("c_bus_sel_i", bus_sel, 4'hF);
    check("c_stall_data", stall_from_data, 0);
    check("c_stall_inst2", stall_from_inst, 1);
    data_req = 1'b0;
    step();
    check("c_inst_wait", inst_ready, 0);
    check("c_stall_inst3", stall_from_inst, 1);
    check("c_data_once", data_ready, 0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h3333_4444;
    step();
    bus_ack  = 1'b0;
    check("c_inst_ready", inst_ready, 1);
    check("c_inst_rdata", inst_rdata, 32'h3333_4444);
    check("c_bus_req_drop", bus_req, 0);
    check("c_data_hold", data_rdata, 32'h1111_2222);
    inst_req = 1'b0;
    step();

    // Store: bus mirrors the fields, data_rdata untouched
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_sel   = 4'h3;
    data_addr  = 32'h40;
    data_wdata = 32'hDEAD_BEEF;
    step();
    check("s_bus_req", bus_req, 1);
    check("s_bus_we", bus_we, 1);
    check("s_bus_sel", bus_sel, 4'h3);
    check("s_bus_addr", bus_addr, 32'h40);
    check("s_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_ack  = 1'b0;
    check("s_data_ready", data_ready, 1);
    check("s_data_rdata", data_rdata, 32'h1111_2222);
    check("s_bus_req_drop", bus_req, 0);
    data_req = 1'b0;
    data_we  = 1'b0;
    step();
    check("s_ready_pulse", data_ready, 0);

    // Timeout: no ack for 4 grant cycles
    data_req  = 1'b1;
    data_sel  = 4'hF;
    data_addr = 32'h80;
    step();
    check("t_bus_req_1", bus_req, 1);
    step();
    step();
    step();
    check("t_bus_req_4", bus_req, 1);
    check("t_no_err_yet", timeout_error, 0);
    step();
    check("t_bus_req_drop", bus_req, 0);
    check("t_data_ready", data_ready, 1);
    check("t_data_rdata", data_rdata, 0);
    check("t_error", timeout_error, 1);
    data_req = 1'b0;
    step();
    check("t_ready_pulse", data_ready, 0);
    check("t_error_sticky", timeout_error, 1);
    // Ack while idle is ignored
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("i_ack_inst", inst_ready, 0);
    check("i_ack_data", data_ready, 0);
    check("i_ack_bus_req", bus_req, 0);

    // Reset mid-grant
    inst_req  = 1'b1;
    inst_addr = 32'h500;
    step();
    check("r_bus_req", bus_req, 1);
    check("r_error_sticky", timeout_error, 1);
    #2 reset = 1'b0;
    #1;
    check("r_bus_req_async", bus_req, 0);
    check("r_bus_addr_async", bus_addr, 0);
    check("r_error_cleared", timeout_error, 0);
    inst_req = 1'b0;
    step();
    reset   = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack = 1'b0;
    check("r_stray_inst", inst_ready, 0);
    check("r_stray_data", data_ready, 0);
    check("r_stray_rdata", inst_rdata, 0);
    check("r_stray_bus_req", bus_req, 0);
    step();
    check("r_idle_after", inst_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
